sdram_test_master: RTL and testbench
====================================

# sdram_test_master

Avalon-MM burst master that drives the `sdram` controller's slave port to self-test the external SDRAM. On `start` it writes a 16-bit LFSR pattern over a configurable address window in fixed-length bursts, reads the window back in the same bursts and compares every word. It reports pass/fail, the error count and the first failing address. It sits directly upstream of `sdram` in the hardware test system, in place of a CPU master.

## Interface
- `BASE_ADDR`, 22'h000000: first word address of the test window.
- `WORDS`, 4096: words tested. Must be a multiple of `BURST`, and `BASE_ADDR + WORDS` must be at most 2^22.
- `BURST`, 8: beats per burst. Must be one of 1, 2, 4, 8, 256.
- `SEED`, 16'hACE1: LFSR seed. Must be nonzero.
- `TIMEOUT`, 1024: maximum idle cycles allowed while waiting for a read beat.
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: single-cycle pulse that starts a test.
- `busy`, out, 1: a test is running.
- `done`, out, 1: level signal; set when a test ends, held until the next accepted `start`.
- `pass`, out, 1: valid while `done`=1; 1 means zero mismatches and no timeout.
- `timeout`, out, 1: a read burst stalled for longer than `TIMEOUT` cycles.
- `err_count`, out, 16: number of mismatched words; saturates at 16'hFFFF.
- `first_err_addr`, out, 22: address of the first mismatched word.
- `m_read`, `m_write`, out, 1: Avalon command strobes.
- `m_address`, out, 22: Avalon word address.
- `m_writedata`, out, 16: write data.
- `m_burstcount`, out, 9: constant value `BURST`.
- `m_byteenable`, out, 2: constant value 2'b11.
- `m_waitrequest`, in, 1: Avalon wait request from the slave.
- `m_readdatavalid`, in, 1: Avalon read data valid.
- `m_readdata`, in, 16: Avalon read data.

## Operation
- Pattern:
  - Next LFSR value = {l[14:0], l[15]^l[13]^l[12]^l[10]}.
  - The word at window offset n is the LFSR value after n steps from `SEED`, so offset 0 holds `SEED` and offset 1 holds 16'h59C3.
  - The LFSR is reloaded with `SEED` at the start of the write phase and again at the start of the read phase.
- States and transitions:
  - IDLE: on `start`, go to WR_BURST.
  - WR_BURST:
    - `m_write`=1.
    - `m_address` = burst base + beat index. Addresses increment per beat, which is what `sdram` requires.
    - A beat is accepted when `m_write` && !`m_waitrequest`. On each accepted beat, advance the beat index and the LFSR.
    - After the last beat is accepted, go to WR_GAP.
  - WR_GAP:
    - One cycle with `m_write`=0; `sdram` uses this to detect the end of a write burst.
    - If more write bursts remain, go to WR_BURST with base += `BURST`.
    - Otherwise, reload the LFSR and go to RD_CMD with base = `BASE_ADDR`.
  - RD_CMD: `m_read`=1 with `m_address` = burst base. Hold the command until `m_waitrequest`=0, then go to RD_DATA.
  - RD_DATA:
    - `m_read`=0.
    - On each `m_readdatavalid`, compare `m_readdata` with the current LFSR value, then advance the LFSR and the beat count.
    - After `BURST` beats, go to RD_CMD for the next burst, or to DONE after the last burst.
  - DONE: assert `done`, deassert `busy`. On `start`, clear all results and go to WR_BURST.
- Only one read burst is outstanding at any time.
- Mismatch handling:
  - Each mismatch increments `err_count` (saturating at 16'hFFFF).
  - `first_err_addr` captures the failing address only when `err_count` was 0 before that mismatch.
- Timeout handling:
  - Count the consecutive cycles in RD_DATA with no read beat.
  - When the count reaches `TIMEOUT`, set `timeout`=1 and go to DONE with `pass`=0.
- Boundary behaviour:
  - `start` while `busy` is ignored.
  - `m_readdatavalid` outside RD_DATA is ignored and is not counted.
- Reset:
  - Asserting `reset` at any time, including mid-burst, aborts the test immediately.
  - Reset values: `busy`=0, `done`=0, `pass`=0, `timeout`=0, `err_count`=0, `first_err_addr`=0, `m_read`=0, `m_write`=0, `m_address`=0, `m_writedata`=0.
  - State returns to IDLE and the LFSR is loaded with `SEED`.

## Timing
- `start` sampled at edge k:
  - `busy`=1 from edge k+1.
  - `m_write`=1, `m_address`=`BASE_ADDR` and `m_writedata`=`SEED` from edge k+1.
- All outputs are registered. Command and data change only on an edge where the beat was accepted, or where a state change occurs.
- A write burst takes `BURST` accepted beats plus 1 gap cycle.
- Each mismatch updates `err_count` at the edge after the beat that caused it.
- After the final read beat at edge m:
  - `done`=1 and `busy`=0 at edge m+1.
  - `pass` at that point already includes the result of the final beat.

## Structure
- Package `sdram_test_pkg` holds:
  - the state enum;
  - the `lfsr16_next` function;
  - the constants `ADDR_W`=22 and `DATA_W`=16, shared with the `sdram` port widths.
- One sub-module, `lfsr16`, with ports clk, reset, load, step, and q (the current LFSR value).
  - It is instantiated once and shared by the write and read phases.

## Test plan
- Behavioural SDRAM model with zero-wait slave, `WORDS`=16, `BURST`=8:
  - Required: 2 write bursts, then 2 read bursts.
  - `pass`=1, `err_count`=0.
  - Second written word is 16'h59C3.
- Model flips bit 0 of the word at `BASE_ADDR`+5 on readback:
  - Required: `pass`=0, `err_count`=1, `first_err_addr`=`BASE_ADDR`+5.
- Slave asserts `m_waitrequest` on random cycles:
  - Required: no beat dropped or duplicated; `pass`=1.
  - `m_write` is 0 for exactly 1 cycle between the write bursts.
- Slave never returns read data:
  - Required: `timeout`=1 after `TIMEOUT` cycles in RD_DATA; `done`=1, `pass`=0.
- Reset asserted during the third write beat:
  - Required: all outputs are at their reset values with no clock edge in between.
  - A subsequent `start` runs the full test and passes.
- `start` pulsed while `busy`=1, then pulsed again in DONE:
  - Required: the first pulse is ignored.
  - The second pulse clears `done`, `err_count` and `first_err_addr`, and restarts the test.

Source files
------------

// File: rtl/sdram_test_master_pkg.sv
// Shared types, widths and the pattern generator step for the SDRAM self-test master.
package sdram_test_pkg;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WR_BURST,
    WR_GAP,
    RD_CMD,
    RD_DATA,
    DONE
  } state_t;

  function automatic logic [DATA_W-1:0] lfsr16_next(input logic [DATA_W-1:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

endpackage

// File: rtl/sdram_test_master_if.sv
// Avalon-MM burst bus between the test master and the sdram slave port.
interface sdram_test_master_if;
  import sdram_test_pkg::*;

  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_writedata;
  logic [8:0]        m_burstcount;
  logic [1:0]        m_byteenable;
  logic              m_waitrequest;
  logic              m_readdatavalid;
  logic [DATA_W-1:0] m_readdata;

  modport master (
    output m_read, m_write, m_address, m_writedata, m_burstcount, m_byteenable,
    input  m_waitrequest, m_readdatavalid, m_readdata
  );

  modport slave (
    input  m_read, m_write, m_address, m_writedata, m_burstcount, m_byteenable,
    output m_waitrequest, m_readdatavalid, m_readdata
  );
endinterface

// File: rtl/sdram_test_master_lfsr16.sv
// 16-bit Fibonacci LFSR holding the expected word for the current window offset.
module lfsr16
  import sdram_test_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else if (load) begin
      q <= SEED;
    end else if (step) begin
      q <= lfsr16_next(q);
    end
  end

endmodule

// File: rtl/sdram_test_master.sv
// Writes an LFSR pattern over an SDRAM window in bursts, reads it back and reports mismatches.
module sdram_test_master
  import sdram_test_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       WORDS     = 4096,
  parameter int unsigned       BURST     = 8,
  parameter logic [DATA_W-1:0] SEED      = 16'hACE1,
  parameter int unsigned       TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [15:0]          err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  sdram_test_master_if.master  avm
);

  localparam int unsigned       AW1       = ADDR_W + 1;
  localparam logic [ADDR_W:0]   LAST_BASE = AW1'(BASE_ADDR) + AW1'(WORDS - BURST);
  localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST);
  localparam logic [8:0]        LAST_BEAT = 9'(BURST - 1);
  localparam logic [31:0]       IDLE_LIM  = 32'(TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [8:0]        beat;
  logic [31:0]       idle_cnt;
  logic [DATA_W-1:0] q;
  logic              lfsr_load;
  logic              lfsr_step;
  logic              last_burst;
  logic              start_ok;
  logic              mismatch;

  assign avm.m_burstcount = 9'(BURST);
  assign avm.m_byteenable = 2'b11;

  always_comb begin
    last_burst = ({1'b0, base} == LAST_BASE);
    start_ok   = start && (state == IDLE || state == DONE);
    mismatch   = (avm.m_readdata != q);
    lfsr_load  = start_ok || (state == WR_GAP && last_burst);
    lfsr_step  = (state == WR_BURST && avm.m_write && !avm.m_waitrequest) ||
                 (state == RD_DATA && avm.m_readdatavalid);
  end

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .q     (q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      base            <= '0;
      beat            <= '0;
      idle_cnt        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      err_count       <= '0;
      first_err_addr  <= '0;
      avm.m_read      <= 1'b0;
      avm.m_write     <= 1'b0;
      avm.m_address   <= '0;
      avm.m_writedata <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= WR_BURST;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            err_count       <= '0;
            first_err_addr  <= '0;
            base            <= BASE_ADDR;
            beat            <= '0;
            avm.m_write     <= 1'b1;
            avm.m_address   <= BASE_ADDR;
            avm.m_writedata <= SEED;
          end
        end
        WR_BURST: begin
          if (avm.m_write && !avm.m_waitrequest) begin
            // Write data runs one LFSR step ahead of q so it is ready on the accepting edge.
            avm.m_writedata <= lfsr16_next(q);
            if (beat == LAST_BEAT) begin
              beat        <= '0;
              avm.m_write <= 1'b0;
              state       <= WR_GAP;
            end else begin
              beat          <= beat + 9'd1;
              avm.m_address <= avm.m_address + 1'b1;
            end
          end
        end
        WR_GAP: begin
          if (!last_burst) begin
            base          <= base + BURST_A;
            avm.m_address <= base + BURST_A;
            avm.m_write   <= 1'b1;
            state         <= WR_BURST;
          end else begin
            base          <= BASE_ADDR;
            avm.m_address <= BASE_ADDR;
            avm.m_read    <= 1'b1;
            state         <= RD_CMD;
          end
        end
        RD_CMD: begin
          if (!avm.m_waitrequest) begin
            avm.m_read <= 1'b0;
            beat       <= '0;
            idle_cnt   <= '0;
            state      <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (avm.m_readdatavalid) begin
            idle_cnt <= '0;
            if (mismatch) begin
              if (err_count != '1) err_count <= err_count + 16'd1;
              if (err_count == '0) first_err_addr <= base + ADDR_W'(beat);
            end
            if (beat == LAST_BEAT) begin
              beat <= '0;
              if (last_burst) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_count == '0) && !mismatch;
              end else begin
                base          <= base + BURST_A;
                avm.m_address <= base + BURST_A;
                avm.m_read    <= 1'b1;
                state         <= RD_CMD;
              end
            end else begin
              beat <= beat + 9'd1;
            end
          end else if (idle_cnt == IDLE_LIM) begin
            timeout <= 1'b1;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_test_master.sv
// Directed bench for sdram_test_master with a behavioural SDRAM slave acting on falling edges.
module tb_sdram_test_master;
  import sdram_test_pkg::*;

  localparam logic [ADDR_W-1:0] BASE   = 22'h000100;
  localparam int unsigned       NW     = 16;
  localparam int unsigned       NB     = 8;
  localparam int unsigned       TMO    = 32;
  localparam logic [DATA_W-1:0] SEED_V = 16'hACE1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, pass, timeout;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;

  sdram_test_master_if avm ();

  sdram_test_master #(
    .BASE_ADDR (BASE),
    .WORDS     (NW),
    .BURST     (NB),
    .SEED      (SEED_V),
    .TIMEOUT   (TMO)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .avm            (avm)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [15:0] mem [0:15];
  int unsigned wcount, wr_err, rbeats, rd_left, rd_off, gap_cycles, rd_cmds;
  logic [15:0] wexp;
  bit rand_wait = 1'b0, flip5 = 1'b0, no_rdata = 1'b0;

  function automatic logic [15:0] tb_next(input logic [15:0] x);
    return {x[14:0], ^(x & 16'hB400)};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    wcount = 0; wr_err = 0; rbeats = 0; rd_left = 0; rd_off = 0;
    gap_cycles = 0; rd_cmds = 0; wexp = SEED_V;
    for (int i = 0; i < 16; i++) mem[i] = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned limit);
    int unsigned n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    if (!done) check("done_wait", 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_pass"},  32'(pass), 32'd0);
    check({tag, "_tmo"},   32'(timeout), 32'd0);
    check({tag, "_errc"},  32'(err_count), 32'd0);
    check({tag, "_ferr"},  32'(first_err_addr), 32'd0);
    check({tag, "_rd"},    32'(avm.m_read), 32'd0);
    check({tag, "_wr"},    32'(avm.m_write), 32'd0);
    check({tag, "_addr"},  32'(avm.m_address), 32'd0);
    check({tag, "_wdata"}, 32'(avm.m_writedata), 32'd0);
  endtask

  // Slave model: decides waitrequest/readdata for the coming rising edge and logs accepted beats.
  initial begin
    avm.m_waitrequest   = 1'b0;
    avm.m_readdatavalid = 1'b0;
    avm.m_readdata      = '0;
    forever begin
      @(negedge clk);
      if (rd_left > 0) begin
        avm.m_readdatavalid = 1'b1;
        avm.m_readdata = (rd_off < NW) ? mem[rd_off[3:0]] : 16'h0000;
        if (flip5 && rd_off == 5) avm.m_readdata = avm.m_readdata ^ 16'h0001;
        rd_off++;
        rd_left--;
        rbeats++;
      end else begin
        avm.m_readdatavalid = 1'b0;
        avm.m_readdata      = '0;
      end
      avm.m_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      if (busy && !avm.m_write && wcount > 0 && wcount < NW) gap_cycles++;
      if (avm.m_write && !avm.m_waitrequest) begin
        if (wcount >= NW || avm.m_address != BASE + ADDR_W'(wcount) || avm.m_writedata != wexp)
          wr_err++;
        else
          mem[wcount[3:0]] = avm.m_writedata;
        wexp = tb_next(wexp);
        wcount++;
      end
      if (avm.m_read && !avm.m_waitrequest) begin
        rd_cmds++;
        if (!no_rdata) begin
          rd_left = NB;
          rd_off  = 32'(avm.m_address - BASE);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    reset_model();
    #12;
    check_reset_vals("rst");
    check("burstcount", 32'(avm.m_burstcount), 32'd8);
    check("byteenable", 32'(avm.m_byteenable), 32'd3);
    tick();
    rst_n = 1'b1;
    tick();

    // Clean run, zero-wait slave
    reset_model();
    pulse_start();
    check("t1_busy",  32'(busy), 32'd1);
    check("t1_wr",    32'(avm.m_write), 32'd1);
    check("t1_addr",  32'(avm.m_address), 32'h100);
    check("t1_wdata", 32'(avm.m_writedata), 32'hACE1);
    wait_done(2000);
    check("t1_pass",   32'(pass), 32'd1);
    check("t1_errc",   32'(err_count), 32'd0);
    check("t1_tmo",    32'(timeout), 32'd0);
    check("t1_idle",   32'(busy), 32'd0);
    check("t1_wcount", wcount, 32'd16);
    check("t1_wr_err", wr_err, 32'd0);
    check("t1_word1",  32'(mem[1]), 32'h59C3);
    check("t1_rbeats", rbeats, 32'd16);
    check("t1_rdcmds", rd_cmds, 32'd2);
    check("t1_gap",    gap_cycles, 32'd1);

    // Bit 0 flipped at offset 5 on readback
    reset_model();
    flip5 = 1'b1;
    pulse_start();
    wait_done(2000);
    flip5 = 1'b0;
    check("t2_pass", 32'(pass), 32'd0);
    check("t2_errc", 32'(err_count), 32'd1);
    check("t2_ferr", 32'(first_err_addr), 32'h105);
    check("t2_tmo",  32'(timeout), 32'd0);

    // Restart from DONE clears results; a start while busy is ignored
    reset_model();
    pulse_start();
    check("t6_done", 32'(done), 32'd0);
    check("t6_errc", 32'(err_count), 32'd0);
    check("t6_ferr", 32'(first_err_addr), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    tick();
    tick();
    pulse_start();
    wait_done(2000);
    check("t6_pass",   32'(pass), 32'd1);
    check("t6_wcount", wcount, 32'd16);
    check("t6_wr_err", wr_err, 32'd0);

    // Random waitrequest
    reset_model();
    rand_wait = 1'b1;
    pulse_start();
    wait_done(4000);
    rand_wait = 1'b0;
    check("t3_pass",   32'(pass), 32'd1);
    check("t3_wcount", wcount, 32'd16);
    check("t3_wr_err", wr_err, 32'd0);
    check("t3_rbeats", rbeats, 32'd16);
    check("t3_gap",    gap_cycles, 32'd1);

    // Slave never returns read data
    reset_model();
    no_rdata = 1'b1;
    pulse_start();
    n = 0;
    while (!avm.m_read && n < 200) begin tick(); n++; end
    n = 0;
    while (avm.m_read && n < 50) begin tick(); n++; end
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    no_rdata = 1'b0;
    check("t4_cycles", n, TMO);
    check("t4_tmo",    32'(timeout), 32'd1);
    check("t4_done",   32'(done), 32'd1);
    check("t4_pass",   32'(pass), 32'd0);

    // Asynchronous reset during the third write beat
    reset_model();
    pulse_start();
    n = 0;
    while (avm.m_address != BASE + 22'd2 && n < 50) begin tick(); n++; end
    check("t5_mid", 32'(avm.m_write), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t5");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    reset_model();
    pulse_start();
    wait_done(2000);
    check("t5_pass",   32'(pass), 32'd1);
    check("t5_wcount", wcount, 32'd16);
    check("t5_wr_err", wr_err, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
